// File: rtl/kap_ctrl_pkg.sv
// rtl/kap_ctrl_pkg.sv - shared constants for the kap control path
// Contents:
//   KAP_FORK_PAR  fork issue mode: request every enabled channel at once
//   KAP_FORK_SEQ  fork issue mode: request one enabled channel at a time, lowest index first
package kap_ctrl_pkg;

  localparam int KAP_FORK_PAR = 0;
  localparam int KAP_FORK_SEQ = 1;

endpackage

// File: rtl/kap_lsb_onehot.sv
// rtl/kap_lsb_onehot.sv - isolate the lowest set bit of a vector
// Ports:
//   x  in   WIDTH  source vector
//   y  out  WIDTH  one-hot lowest set bit of x, or zero when x is zero
module kap_lsb_onehot #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  // Two's complement flips every bit above the lowest one, so the AND keeps only that bit.
  assign y = x & (~x + WIDTH'(1));

endmodule

// File: rtl/kap_ctrl_fork_n.sv
// rtl/kap_ctrl_fork_n.sv - N-way req/ack fork controller with stall timeout and transaction count
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous active-high reset
//   t_req      in   1      upstream request, held until t_ack
//   t_ack      out  1      upstream acknowledge (combinational)
//   t_mask     in   N_CH   channels taking part in the current transaction
//   i_req      out  N_CH   downstream requests
//   i_ack      in   N_CH   downstream acknowledges, qualified by i_req
//   tmo_limit  in   TMO_W  stall cycles before error, 0 disables
//   err_clr    in   1      clears tmo_err / tmo_ch
//   tmo_err    out  1      sticky timeout flag
//   tmo_ch     out  N_CH   i_req snapshot at the first timeout
//   busy       out  1      transaction outstanding and not acknowledged this cycle
//   txn_cnt    out  CNT_W  completed upstream transactions, wrapping
module kap_ctrl_fork_n
  import kap_ctrl_pkg::*;
#(
  parameter int N_CH  = 5,
  parameter int SEQ   = KAP_FORK_PAR,
  parameter int TMO_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             t_req,
  output logic             t_ack,
  input  logic [N_CH-1:0]  t_mask,
  output logic [N_CH-1:0]  i_req,
  input  logic [N_CH-1:0]  i_ack,
  input  logic [TMO_W-1:0] tmo_limit,
  input  logic             err_clr,
  output logic             tmo_err,
  output logic [N_CH-1:0]  tmo_ch,
  output logic             busy,
  output logic [CNT_W-1:0] txn_cnt
);

  logic [N_CH-1:0]  q_done;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  req_sel;
  logic [N_CH-1:0]  hit;
  logic [TMO_W-1:0] q_cnt;
  logic             tmo_hit;

  // Channels still owed an acknowledge in this transaction.
  assign pending = t_mask & ~q_done;

  generate
    if (SEQ == KAP_FORK_SEQ) begin : g_seq
      logic [N_CH-1:0] lsb;
      kap_lsb_onehot #(
        .WIDTH(N_CH)
      ) u_lsb (
        .x(pending),
        .y(lsb)
      );
      assign req_sel = lsb;
    end else begin : g_par
      assign req_sel = pending;
    end
  endgenerate

  assign i_req = t_req ? req_sel : '0;

  // Acks only count on channels currently being requested.
  assign hit = i_req & i_ack;

  // Done when every owed channel is either already done or acking right now.
  assign t_ack = t_req & ~(|(pending & ~hit));
  assign busy  = t_req & ~t_ack;

  assign tmo_hit = busy && (tmo_limit != '0) && (q_cnt == tmo_limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_done  <= '0;
      q_cnt   <= '0;
      tmo_err <= 1'b0;
      tmo_ch  <= '0;
      txn_cnt <= '0;
    end else begin
      // Dropping t_req (normal end or abort) or acknowledging starts the next transaction clean.
      q_done <= (q_done | hit) & ~{N_CH{t_ack}} & {N_CH{t_req}};

      if (busy) begin
        if (~&q_cnt) begin
          q_cnt <= q_cnt + TMO_W'(1);
        end
      end else begin
        q_cnt <= '0;
      end

      if (tmo_hit) begin
        tmo_err <= 1'b1;
      end else if (err_clr) begin
        tmo_err <= 1'b0;
      end

      // Keep the first snapshot; a clear coinciding with a new event re-arms it with the new one.
      if (tmo_hit && (!tmo_err || err_clr)) begin
        tmo_ch <= i_req;
      end else if (err_clr) begin
        tmo_ch <= '0;
      end

      if (t_ack) begin
        txn_cnt <= txn_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_kap_ctrl_fork_n.sv
// tb/tb_kap_ctrl_fork_n.sv - self-checking bench for kap_ctrl_fork_n in parallel and sequential modes
module tb_kap_ctrl_fork_n;

  localparam int N  = 5;
  localparam int TW = 8;
  localparam int CW = 16;

  localparam int S_TACK   = 0;
  localparam int S_IREQ   = 1;
  localparam int S_BUSY   = 2;
  localparam int S_ERR    = 3;
  localparam int S_CH     = 4;
  localparam int S_CNT    = 5;
  localparam int S_QCNT   = 6;
  localparam int S_QDONE  = 7;
  localparam int S_TACK_S = 8;
  localparam int S_IREQ_S = 9;
  localparam int S_CNT_S  = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [TW-1:0] tmo_limit;
  logic          err_clr;

  logic          t_req, t_ack, busy, tmo_err;
  logic [N-1:0]  t_mask, i_req, i_ack, tmo_ch;
  logic [CW-1:0] txn_cnt;

  logic          t_req_s, t_ack_s, busy_s, tmo_err_s;
  logic [N-1:0]  t_mask_s, i_req_s, i_ack_s, tmo_ch_s;
  logic [CW-1:0] txn_cnt_s;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  kap_ctrl_fork_n #(.N_CH(N), .SEQ(0), .TMO_W(TW), .CNT_W(CW)) u_par (
    .clk(clk), .reset(reset), .t_req(t_req), .t_ack(t_ack), .t_mask(t_mask),
    .i_req(i_req), .i_ack(i_ack), .tmo_limit(tmo_limit), .err_clr(err_clr),
    .tmo_err(tmo_err), .tmo_ch(tmo_ch), .busy(busy), .txn_cnt(txn_cnt)
  );

  kap_ctrl_fork_n #(.N_CH(N), .SEQ(1), .TMO_W(TW), .CNT_W(CW)) u_seq (
    .clk(clk), .reset(reset), .t_req(t_req_s), .t_ack(t_ack_s), .t_mask(t_mask_s),
    .i_req(i_req_s), .i_ack(i_ack_s), .tmo_limit(tmo_limit), .err_clr(err_clr),
    .tmo_err(tmo_err_s), .tmo_ch(tmo_ch_s), .busy(busy_s), .txn_cnt(txn_cnt_s)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_TACK:   return 32'(t_ack);
      S_IREQ:   return 32'(i_req);
      S_BUSY:   return 32'(busy);
      S_ERR:    return 32'(tmo_err);
      S_CH:     return 32'(tmo_ch);
      S_CNT:    return 32'(txn_cnt);
      S_QCNT:   return 32'(u_par.q_cnt);
      S_QDONE:  return 32'(u_par.q_done);
      S_TACK_S: return 32'(t_ack_s);
      S_IREQ_S: return 32'(i_req_s);
      S_CNT_S:  return 32'(txn_cnt_s);
      default:  return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  // Sample mid-cycle, compare everything expected for this cycle, then move to just after the next edge.
  task automatic settle();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, observe(e.sig), e.val);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] p2_ack  [0:7];
    logic [N-1:0] p2_ireq [0:7];
    logic         p2_tack [0:7];
    logic [N-1:0] p3_ack  [0:3];
    logic [N-1:0] p3_ireq [0:3];
    logic         p3_tack [0:3];

    p2_ack  = '{5'b00000, 5'b00001, 5'b00000, 5'b10000, 5'b11010, 5'b00000, 5'b00100, 5'b00000};
    p2_ireq = '{5'b10101, 5'b10101, 5'b10100, 5'b10100, 5'b00100, 5'b00100, 5'b00100, 5'b00000};
    p2_tack = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    p3_ack  = '{5'b01010, 5'b11111, 5'b11111, 5'b11111};
    p3_ireq = '{5'b00001, 5'b00001, 5'b00010, 5'b01000};
    p3_tack = '{1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; tmo_limit = '0; err_clr = 1'b0;
    t_req = 1'b0; t_mask = '0; i_ack = '0;
    t_req_s = 1'b0; t_mask_s = '0; i_ack_s = '0;
    @(posedge clk);
    #1;
    push("rst_tack", S_TACK, 0); push("rst_ireq", S_IREQ, 0); push("rst_busy", S_BUSY, 0);
    push("rst_err", S_ERR, 0); push("rst_ch", S_CH, 0); push("rst_cnt", S_CNT, 0);
    push("rst_qcnt", S_QCNT, 0); push("rst_cnt_s", S_CNT_S, 0);
    settle();
    reset = 1'b0;

    // All channels acking at once: zero-latency ack, three back-to-back transactions.
    t_req = 1'b1; t_mask = 5'b11111; i_ack = 5'b11111;
    push("p1_tack", S_TACK, 1); push("p1_ireq", S_IREQ, 5'b11111);
    push("p1_busy", S_BUSY, 0); push("p1_cnt0", S_CNT, 0);
    settle();
    push("p1_tack_b2b", S_TACK, 1); push("p1_ireq_b2b", S_IREQ, 5'b11111); push("p1_cnt1", S_CNT, 1);
    settle();
    push("p1_cnt2", S_CNT, 2);
    settle();
    t_req = 1'b0;
    push("p1_cnt3", S_CNT, 3); push("p1_idle_tack", S_TACK, 0);
    settle();

    // Staggered acks on a sparse mask, including acks on channels not being requested.
    t_mask = 5'b10101;
    for (int c = 0; c < 8; c++) begin
      t_req = (c < 7);
      i_ack = p2_ack[c];
      push($sformatf("p2_ireq_c%0d", c), S_IREQ, 32'(p2_ireq[c]));
      push($sformatf("p2_tack_c%0d", c), S_TACK, 32'(p2_tack[c]));
      settle();
    end
    push("p2_cnt", S_CNT, 4); push("p2_err", S_ERR, 0);
    settle();

    // Sequential issue; the first cycle acks only channels that are not the current one.
    t_mask_s = 5'b01011;
    for (int c = 0; c < 4; c++) begin
      t_req_s = 1'b1;
      i_ack_s = p3_ack[c];
      push($sformatf("p3_ireq_c%0d", c), S_IREQ_S, 32'(p3_ireq[c]));
      push($sformatf("p3_tack_c%0d", c), S_TACK_S, 32'(p3_tack[c]));
      settle();
    end
    t_req_s = 1'b0; i_ack_s = '0;
    push("p3_ireq_idle", S_IREQ_S, 0); push("p3_cnt", S_CNT_S, 1);
    settle();

    // Timeout after four stalled cycles on channel 1.
    tmo_limit = 8'd4; t_mask = 5'b00011; t_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      i_ack = (c == 0) ? 5'b00001 : 5'b00000;
      push($sformatf("p4_ireq_c%0d", c), S_IREQ, (c == 0) ? 32'b00011 : 32'b00010);
      push($sformatf("p4_err_c%0d", c), S_ERR, 0);
      settle();
    end
    i_ack = '0;
    push("p4_err_set", S_ERR, 1); push("p4_ch", S_CH, 5'b00010); push("p4_busy", S_BUSY, 1);
    settle();
    i_ack = 5'b00010;
    push("p4_late_tack", S_TACK, 1); push("p4_err_hold", S_ERR, 1);
    settle();
    t_req = 1'b0; i_ack = '0; err_clr = 1'b1;
    push("p4_cnt", S_CNT, 5); push("p4_err_pre_clr", S_ERR, 1);
    settle();
    err_clr = 1'b0;
    push("p4_err_clr", S_ERR, 0); push("p4_ch_clr", S_CH, 0);
    settle();

    // Clear coinciding with the timeout event: set wins.
    t_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      err_clr = (c == 4);
      settle();
    end
    err_clr = 1'b0;
    push("p4_set_wins", S_ERR, 1); push("p4_set_wins_ch", S_CH, 5'b00011);
    settle();
    i_ack = 5'b00011;
    push("p4_tack2", S_TACK, 1);
    settle();
    t_req = 1'b0; i_ack = '0; err_clr = 1'b1;
    push("p4_cnt2", S_CNT, 6);
    settle();
    err_clr = 1'b0;
    push("p4_err_clr2", S_ERR, 0);
    settle();

    // Empty mask: acknowledge immediately every cycle.
    tmo_limit = '0; t_mask = '0; t_req = 1'b1;
    push("p5_tack", S_TACK, 1); push("p5_ireq", S_IREQ, 0); push("p5_busy", S_BUSY, 0); push("p5_cnt0", S_CNT, 6);
    settle();
    push("p5_cnt1", S_CNT, 7);
    settle();
    push("p5_cnt2", S_CNT, 8);
    settle();
    t_req = 1'b0;
    push("p5_cnt3", S_CNT, 9);
    settle();

    // Timeout disabled with a long stall: stall counter saturates, no error.
    t_mask = 5'b00001; t_req = 1'b1;
    for (int c = 0; c < 300; c++) begin
      settle();
    end
    push("p6_qcnt_sat", S_QCNT, 255); push("p6_err", S_ERR, 0); push("p6_busy", S_BUSY, 1);
    settle();
    i_ack = 5'b00001;
    push("p6_tack", S_TACK, 1);
    settle();
    t_req = 1'b0; i_ack = '0;
    push("p6_cnt", S_CNT, 10); push("p6_qcnt_clr", S_QCNT, 0);
    settle();

    // Reset in the middle of a transaction with an error pending.
    tmo_limit = 8'd2; t_mask = 5'b00111; t_req = 1'b1; i_ack = 5'b00011;
    push("p7_ireq0", S_IREQ, 5'b00111);
    settle();
    i_ack = '0;
    push("p7_ireq1", S_IREQ, 5'b00100);
    settle();
    settle();
    push("p7_err", S_ERR, 1); push("p7_qdone", S_QDONE, 5'b00011);
    settle();
    reset = 1'b1;
    push("p7_rst_qdone", S_QDONE, 0); push("p7_rst_err", S_ERR, 0); push("p7_rst_cnt", S_CNT, 0);
    push("p7_rst_ireq", S_IREQ, 5'b00111);
    settle();
    reset = 1'b0;
    push("p7_rel_ireq", S_IREQ, 5'b00111);
    settle();
    i_ack = 5'b00111;
    push("p7_tack", S_TACK, 1);
    settle();
    t_req = 1'b0; i_ack = '0;
    push("p7_cnt", S_CNT, 1);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
